// File: rtl/clk_mul_add.sv
// Sequential 16x16 unsigned multiply-accumulate, pd = qt*dv + rm.
// Shift-add datapath that retires one multiplier bit per clock in an 18-clock slot.
module clk_mul_add (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] qt,
  input  logic [15:0] dv,
  input  logic [15:0] rm,
  input  logic        irdy,
  output logic [31:0] pd,
  output logic        ordy,
  output logic        busy
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;

  logic [1:0]  r_state;
  logic [16:0] r_hi;
  logic [15:0] r_lo;
  logic [15:0] r_mreg;
  logic [3:0]  r_kreg;
  logic [31:0] r_pd;
  logic        r_ordy;
  logic        r_busy;
  logic [16:0] w_addend;
  logic [16:0] w_sum;

  // Partial-product add; r_hi[16] is always clear between iterations.
  always_comb begin
    w_addend = 17'd0;
    if (r_lo[0]) begin
      w_addend = {1'b0, r_mreg};
    end else begin
      w_addend = 17'd0;
    end
    w_sum = r_hi + w_addend;
  end

  // Control FSM and shift-add datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S0;
      r_hi    <= 17'd0;
      r_lo    <= 16'd0;
      r_mreg  <= 16'd0;
      r_kreg  <= 4'd0;
      r_pd    <= 32'd0;
      r_ordy  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S0: begin
          r_hi   <= {1'b0, rm};
          r_lo   <= qt;
          r_mreg <= dv;
          r_kreg <= 4'd15;
          r_ordy <= 1'b0;
          if (irdy) begin
            r_state <= S1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S0;
            r_busy  <= 1'b0;
          end
        end
        S1: begin
          // 33-bit right shift of {sum, lo}; the carry lands in hi[15].
          r_hi   <= {1'b0, w_sum[16:1]};
          r_lo   <= {w_sum[0], r_lo[15:1]};
          r_kreg <= r_kreg - 4'd1;
          r_busy <= 1'b1;
          if (r_kreg == 4'd0) begin
            r_state <= S2;
            r_pd    <= {w_sum, r_lo[15:1]};
            r_ordy  <= 1'b1;
          end else begin
            r_state <= S1;
            r_ordy  <= 1'b0;
          end
        end
        S2: begin
          r_state <= S0;
          r_ordy  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S0;
          r_ordy  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pd   = r_pd;
  assign ordy = r_ordy;
  assign busy = r_busy;

endmodule

// File: tb/tb_clk_mul_add.sv
// Self-checking bench for clk_mul_add: cycle-level behavioural model plus directed literals.
module tb_clk_mul_add;

  logic        clk;
  logic        reset;
  logic [15:0] qt, dv, rm;
  logic        irdy;
  logic [31:0] pd;
  logic        ordy;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  clk_mul_add dut (
    .clk (clk), .reset(reset), .qt(qt), .dv(dv), .rm(rm),
    .irdy(irdy), .pd(pd), .ordy(ordy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation accepted at edge N completes at N+16,
  // keeps busy through N+16, and the next accept may happen at N+18.
  int          cyc = 0;
  int          acc_cyc = -100;
  longint      m_res = 0;
  logic [31:0] e_pd = 32'd0;
  logic        e_ordy = 1'b0;
  logic        e_busy = 1'b0;
  int          n_accepts = 0;
  int          n_ordy = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cyc = cyc - 100;
      e_pd    = 32'd0;
      e_ordy  = 1'b0;
      e_busy  = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (irdy && (cyc - acc_cyc >= 18)) begin
        acc_cyc = cyc;
        m_res   = longint'(qt) * longint'(dv) + longint'(rm);
        n_accepts++;
      end
      e_ordy = (cyc - acc_cyc == 16);
      e_busy = (cyc - acc_cyc >= 0) && (cyc - acc_cyc <= 16);
      if (e_ordy) e_pd = m_res[31:0];
    end
  end

  // Single compare process on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_pd",   pd,   e_pd);
      chk("model_ordy", ordy, e_ordy);
      chk("model_busy", busy, e_busy);
      if (ordy) n_ordy++;
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [31:0] exp, input string nm);
    int n;
    @(negedge clk);
    qt = a; dv = b; rm = c; irdy = 1'b1;
    @(negedge clk);
    irdy = 1'b0;
    qt = 16'($urandom); dv = 16'($urandom); rm = 16'($urandom);
    n = 0;
    while (!ordy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd16);
    chk({nm, "_pd"}, pd, exp);
    @(negedge clk);
    chk({nm, "_ordy_1clk"}, ordy, 1'b0);
    chk({nm, "_pd_hold"}, pd, exp);
  endtask

  initial begin
    longint dividend;
    logic [15:0] d;
    int acc0;
    qt = 16'd0; dv = 16'd0; rm = 16'd0; irdy = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_pd",   pd,   32'd0);
    chk("reset_ordy", ordy, 1'b0);
    chk("reset_busy", busy, 1'b0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    run_op(16'h1234, 16'h5678, 16'h9ABC, 32'h06269B1C, "basic");
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, "max");
    run_op(16'h0000, 16'hFFFF, 16'h0007, 32'h00000007, "zero_qt");
    run_op(16'h0001, 16'h0000, 16'h0000, 32'h00000000, "zero_dv");

    // Reset in the middle of an operation.
    @(negedge clk);
    qt = 16'h1111; dv = 16'h2222; rm = 16'h3333; irdy = 1'b1;
    @(negedge clk);
    irdy = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pd",   pd,   32'd0);
    chk("midrst_ordy", ordy, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc0 = n_ordy;
    repeat (20) @(negedge clk);
    chk("midrst_no_ordy", 64'(n_ordy - acc0), 64'd0);
    run_op(16'd3, 16'd5, 16'd1, 32'h00000010, "post_rst");

    // Divider round trip: split a dividend into {qt, dv, rm} and rebuild it.
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom_range(1, 65535));
      dividend = longint'({$urandom, $urandom}) % (longint'(d) * 64'd65536);
      if (dividend < 0) dividend = -dividend;
      run_op(16'(dividend / longint'(d)), d, 16'(dividend % longint'(d)),
             32'(dividend), "divider");
    end

    // irdy held high with new operands each accept: spacing must be 18 clocks.
    acc0 = n_accepts;
    @(negedge clk);
    irdy = 1'b1;
    qt = 16'($urandom); dv = 16'($urandom); rm = 16'($urandom);
    repeat (18 * 5) begin
      @(negedge clk);
      qt = 16'($urandom); dv = 16'($urandom); rm = 16'($urandom);
    end
    chk("held_accepts", 64'(n_accepts - acc0), 64'd5);

    // Random regression with sporadic irdy drops and pulses while busy.
    acc0 = n_ordy;
    repeat (2500 * 18) begin
      @(negedge clk);
      irdy = ($urandom_range(0, 9) != 0);
      qt = 16'($urandom); dv = 16'($urandom); rm = 16'($urandom);
    end
    irdy = 1'b0;
    repeat (20) @(negedge clk);
    chk("random_ops_done", 64'(n_ordy - acc0 > 2000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
